// File: rtl/steer_en_dp_if.sv
// ---------------------------------------------------------------------------
// steer_en_dp_if
// Bundles the load-cell sample bus, the settle-timer control and the filtered
// result bus of the steering-enable datapath stage.
//
// Handshake: ld_vld is a one-cycle strobe with no back-pressure. lft_ld and
// rght_ld are sampled on every rising clk edge where ld_vld=1, and there is no
// ready signal. clr_tmr is a level that clears the settle timer on each edge
// where it is high.
//
// Signals:
//   lft_ld, rght_ld   raw 12-bit unsigned load-cell samples   (master -> slave)
//   ld_vld            sample strobe                           (master -> slave)
//   clr_tmr           synchronous settle-timer clear          (master -> slave)
//   lft_avg, rght_avg filtered 12-bit loads                   (slave -> master)
//   sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16
//                     registered weight and balance flags     (slave -> master)
//   tmr_full          settle timer reached its terminal count (slave -> master)
// ---------------------------------------------------------------------------
interface steer_en_dp_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        clr_tmr;
  logic [11:0] lft_avg;
  logic [11:0] rght_avg;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;

  modport master (
    output lft_ld, rght_ld, ld_vld, clr_tmr,
    input  lft_avg, rght_avg, sum_gt_min, sum_lt_min,
           diff_gt_1_4, diff_gt_15_16, tmr_full
  );

  modport slave (
    input  lft_ld, rght_ld, ld_vld, clr_tmr,
    output lft_avg, rght_avg, sum_gt_min, sum_lt_min,
           diff_gt_1_4, diff_gt_15_16, tmr_full
  );
endinterface

// File: rtl/steer_en_dp.sv
// ---------------------------------------------------------------------------
// steer_en_dp
// Datapath stage feeding the steering-enable state machine. Each load-cell
// side is filtered with a 4-sample moving average. Registered hysteresis
// weight flags and rider-balance flags are derived from the two averages. The
// block also contains the settle timer that the state machine clears and polls.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    steer_en_dp_if.slave (samples/strobe/timer clear in, averages,
//          flags and tmr_full out)
//
// Pipeline: the history shifts on edge N (ld_vld in cycle N), the averages
// follow on edge N+1 and the flags on edge N+2.
// ---------------------------------------------------------------------------
module steer_en_dp #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040,
  parameter logic [25:0] TMR_CNT          = 26'd65_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  steer_en_dp_if.slave      bus
);

  // Thresholds are formed at 13 bits so MIN+HYST cannot wrap.
  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  logic [11:0] lft_h_q [4];
  logic [11:0] rght_h_q[4];
  logic [11:0] lft_avg_q,  lft_avg_d;
  logic [11:0] rght_avg_q, rght_avg_d;
  logic [13:0] lft_sum,    rght_sum;
  logic [12:0] sum_c,      diff_c;
  logic        sum_gt_min_q, sum_lt_min_q, diff_gt_1_4_q, diff_gt_15_16_q;
  logic [25:0] tmr_q, tmr_d;

  // Sample history: position 0 is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        lft_h_q[i]  <= '0;
        rght_h_q[i] <= '0;
      end
    end else if (bus.ld_vld) begin
      lft_h_q[0]  <= bus.lft_ld;
      rght_h_q[0] <= bus.rght_ld;
      for (int i = 1; i < 4; i++) begin
        lft_h_q[i]  <= lft_h_q[i-1];
        rght_h_q[i] <= rght_h_q[i-1];
      end
    end
  end

  // Averages are recomputed every cycle. Between strobes the history holds,
  // so the averages hold as well.
  always_comb begin
    lft_sum    = {2'b00, lft_h_q[0]}  + {2'b00, lft_h_q[1]}
               + {2'b00, lft_h_q[2]}  + {2'b00, lft_h_q[3]};
    rght_sum   = {2'b00, rght_h_q[0]} + {2'b00, rght_h_q[1]}
               + {2'b00, rght_h_q[2]} + {2'b00, rght_h_q[3]};
    lft_avg_d  = 12'(lft_sum >> 2);
    rght_avg_d = 12'(rght_sum >> 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_avg_q  <= '0;
      rght_avg_q <= '0;
    end else begin
      lft_avg_q  <= lft_avg_d;
      rght_avg_q <= rght_avg_d;
    end
  end

  // The difference subtracts the smaller value from the larger one, so it
  // never wraps.
  always_comb begin
    sum_c  = {1'b0, lft_avg_q} + {1'b0, rght_avg_q};
    diff_c = (lft_avg_q >= rght_avg_q) ? ({1'b0, lft_avg_q} - {1'b0, rght_avg_q})
                                       : ({1'b0, rght_avg_q} - {1'b0, lft_avg_q});
  end

  // The rider is treated as off until the filtered data proves otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_gt_min_q    <= 1'b0;
      sum_lt_min_q    <= 1'b1;
      diff_gt_1_4_q   <= 1'b0;
      diff_gt_15_16_q <= 1'b0;
    end else begin
      sum_gt_min_q    <= (sum_c > SUM_HI);
      sum_lt_min_q    <= (sum_c < SUM_LO);
      diff_gt_1_4_q   <= (diff_c > (sum_c >> 2));
      diff_gt_15_16_q <= (diff_c > (sum_c - (sum_c >> 4)));
    end
  end

  // Settle timer: clear has priority, otherwise count up and saturate.
  always_comb begin
    tmr_d = tmr_q;
    if (bus.clr_tmr)           tmr_d = '0;
    else if (tmr_q < TMR_CNT)  tmr_d = tmr_q + 26'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign bus.lft_avg       = lft_avg_q;
  assign bus.rght_avg      = rght_avg_q;
  assign bus.sum_gt_min    = sum_gt_min_q;
  assign bus.sum_lt_min    = sum_lt_min_q;
  assign bus.diff_gt_1_4   = diff_gt_1_4_q;
  assign bus.diff_gt_15_16 = diff_gt_15_16_q;
  assign bus.tmr_full      = (tmr_q == TMR_CNT);

endmodule

// File: tb/tb_steer_en_dp.sv
// ---------------------------------------------------------------------------
// tb_steer_en_dp
// Testbench for steer_en_dp with TMR_CNT reduced to 32. A reference model
// keeps the last four samples of each side in queues. It derives the averages
// and flags from those samples with integer arithmetic and advances one step
// per clock edge. Directed steady-state cases, then randomized stimulus.
// ---------------------------------------------------------------------------
module tb_steer_en_dp;

  localparam int T_CNT = 32;
  localparam int MIN_W = 'h200;
  localparam int HYST  = 'h040;

  logic clk;
  logic rst_n;
  steer_en_dp_if bus();

  steer_en_dp #(.TMR_CNT(26'd32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  int lq[$];
  int rq[$];
  int m_lavg, m_ravg;
  logic [3:0] m_flags;
  int m_tmr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int avg_of(input int q[$]);
    int s;
    s = 0;
    foreach (q[i]) s += q[i];
    return s / 4;
  endfunction

  // Returns {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}.
  function automatic logic [3:0] flags_of(input int l, input int r);
    int sum, diff;
    sum  = l + r;
    diff = (l > r) ? l - r : r - l;
    return {sum > MIN_W + HYST, sum < MIN_W - HYST,
            diff > sum / 4, diff > sum - sum / 16};
  endfunction

  task automatic model_reset();
    lq = {0, 0, 0, 0};
    rq = {0, 0, 0, 0};
    m_lavg  = 0;
    m_ravg  = 0;
    m_flags = 4'b0100;
    m_tmr   = 0;
  endtask

  // One clock edge: every stage uses the values from before the edge.
  task automatic model_edge(input bit vld, input int l, input int r, input bit clr);
    m_flags = flags_of(m_lavg, m_ravg);
    m_lavg  = avg_of(lq);
    m_ravg  = avg_of(rq);
    if (vld) begin
      lq.push_front(l); void'(lq.pop_back());
      rq.push_front(r); void'(rq.pop_back());
    end
    if (clr)                m_tmr = 0;
    else if (m_tmr < T_CNT) m_tmr++;
  endtask

  task automatic check_all();
    check("lft_avg",  32'(bus.lft_avg),  32'(m_lavg));
    check("rght_avg", 32'(bus.rght_avg), 32'(m_ravg));
    check("flags", 32'({bus.sum_gt_min, bus.sum_lt_min, bus.diff_gt_1_4, bus.diff_gt_15_16}),
          32'(m_flags));
    check("tmr_full", 32'(bus.tmr_full), 32'(m_tmr == T_CNT));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit vld, input int l, input int r, input bit clr);
    bus.ld_vld  = vld;
    bus.lft_ld  = 12'(l);
    bus.rght_ld = 12'(r);
    bus.clr_tmr = clr;
    @(posedge clk);
    model_edge(vld, l, r, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.ld_vld  = 1'b0;
    bus.lft_ld  = '0;
    bus.rght_ld = '0;
    bus.clr_tmr = 1'b0;
    model_reset();
    #1;
    check_all();              // the reset acts without waiting for a clock edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Four strobes of a steady load pair, then two idle cycles to flush the pipe.
  task automatic steady(input int l, input int r, input logic [3:0] exp_flags, input string tag);
    for (int i = 0; i < 4; i++) cycle(1'b1, l, r, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    check({tag, "_lavg"}, 32'(bus.lft_avg),  32'(l));
    check({tag, "_ravg"}, 32'(bus.rght_avg), 32'(r));
    check({tag, "_flags"}, 32'({bus.sum_gt_min, bus.sum_lt_min, bus.diff_gt_1_4,
                                bus.diff_gt_15_16}), 32'(exp_flags));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n       = 1'b1;
    bus.ld_vld  = 1'b0;
    bus.lft_ld  = '0;
    bus.rght_ld = '0;
    bus.clr_tmr = 1'b0;
    model_reset();

    do_reset();
    check("rst_avg", 32'(bus.lft_avg), 32'h0);
    check("rst_lt",  32'(bus.sum_lt_min), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b0);

    // Ramp from zero history: the first average is 0x180/4.
    cycle(1'b1, 'h180, 'h180, 1'b0);
    cycle(1'b1, 'h180, 'h180, 1'b0);
    check("ramp_first", 32'(bus.lft_avg), 32'h060);
    cycle(1'b1, 'h180, 'h180, 1'b0);
    cycle(1'b1, 'h180, 'h180, 1'b0);
    steady('h180, 'h180, 4'b1000, "s180");

    steady('h300, 'h100, 4'b1010, "s300_100");
    steady('h3F0, 'h010, 4'b1011, "s3f0_010");
    steady('h010, 'h3F0, 4'b1011, "s010_3f0");
    steady('h100, 'h100, 4'b0000, "band");
    steady('h0DF, 'h0DF, 4'b0100, "below");

    // Timer: rises exactly T_CNT edges after the clear edge.
    cycle(1'b0, 0, 0, 1'b1);
    n = 0;
    while (!bus.tmr_full && n <= 100) begin
      cycle(1'b0, 0, 0, 1'b0);
      n++;
    end
    check("tmr_rise", 32'(n), 32'(T_CNT));
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b0);
    check("tmr_hold", 32'(bus.tmr_full), 32'h1);
    cycle(1'b0, 0, 0, 1'b1);
    check("tmr_clr", 32'(bus.tmr_full), 32'h0);

    // Clear lands on the edge that would have reached the terminal count.
    for (int i = 0; i < T_CNT - 1; i++) cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    check("tmr_clr_at_full", 32'(bus.tmr_full), 32'h0);

    // Reset while the timer is full and the averages are loaded.
    steady('h200, 'h180, 4'b1000, "pre_rst");
    for (int i = 0; i < T_CNT; i++) cycle(1'b0, 0, 0, 1'b0);
    check("tmr_pre_rst", 32'(bus.tmr_full), 32'h1);
    do_reset();
    check("rst_mid_tmr", 32'(bus.tmr_full), 32'h0);
    check("rst_mid_avg", 32'(bus.rght_avg), 32'h0);

    // Randomized traffic: full range, and a band around the weight thresholds.
    for (int i = 0; i < 600; i++) begin
      bit vld, clr;
      int l, r;
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if (i < 300) begin
        l = $urandom_range(0, 4095);
        r = $urandom_range(0, 4095);
      end else begin
        l = $urandom_range(0, 'h180);
        r = $urandom_range(0, 'h180);
      end
      if (i == 450) do_reset();
      cycle(vld, l, r, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit to guarantee termination.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/steer_en_dp.md
Name: steer_en_dp

Overview:
Datapath stage directly upstream of the steering-enable state machine. It takes raw left/right load-cell samples from the A2D interface, filters each side with a 4-sample moving average, and produces registered hysteresis weight flags and rider-balance flags. It also contains the 1.3 s settle timer: the state machine clears it through clr_tmr and reads tmr_full back. The filtered loads are also exported for diagnostics.

Parameters:
MIN_RIDER_WEIGHT, 12'h200, nominal minimum rider weight in load-cell counts.
HYSTERESIS, 12'h040, half-width of the weight hysteresis band.
TMR_CNT, 26'd65_000_000, cycles to tmr_full; 1.3 s at 50 MHz. The bench overrides this to 26'd32 for fast simulation.

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  reset, asynchronous, active-low
lft_ld  input  12  raw left load cell, unsigned
rght_ld  input  12  raw right load cell, unsigned
ld_vld  input  1  one-cycle strobe; lft_ld/rght_ld valid this cycle
clr_tmr  input  1  synchronous clear of settle timer
lft_avg  output  12  filtered left load
rght_avg  output  12  filtered right load
sum_gt_min  output  1  filtered sum > MIN_RIDER_WEIGHT+HYSTERESIS
sum_lt_min  output  1  filtered sum < MIN_RIDER_WEIGHT-HYSTERESIS
diff_gt_1_4  output  1  |lft_avg-rght_avg| > sum/4
diff_gt_15_16  output  1  |lft_avg-rght_avg| > sum - sum/16
tmr_full  output  1  settle timer reached TMR_CNT

Behaviour:
- Reset (async) clears all history registers, both averages, the timer, sum_gt_min, diff_gt_1_4, diff_gt_15_16 and tmr_full to 0. sum_lt_min resets to 1, so the rider is treated as off.
- Filter: each side has a 4-entry shift register.
  - On a clk edge with ld_vld=1, the new sample enters at position 0 and the oldest is discarded. With ld_vld=0 the history holds.
  - avg = (h0+h1+h2+h3)>>2, using a 14-bit sum and truncating. lft_avg/rght_avg are registered and update on the edge after the history update.
  - Latency: ld_vld asserted in cycle N; history updates at edge N; averages at edge N+1; flags at edge N+2. Back-to-back ld_vld every cycle is legal and fully pipelined.
- Flag arithmetic uses registered averages and is done unsigned in 13 bits.
  - sum = lft_avg+rght_avg.
  - diff = |lft_avg-rght_avg|, computed without wrap by subtracting the smaller from the larger.
  - diff_gt_1_4 = diff > (sum>>2).
  - diff_gt_15_16 = diff > (sum-(sum>>4)).
  - sum_gt_min = sum > (MIN_RIDER_WEIGHT+HYSTERESIS). sum_lt_min = sum < (MIN_RIDER_WEIGHT-HYSTERESIS). Both thresholds are evaluated at 13 bits.
  - Inside the band both weight flags are 0. They are never both 1.
  - All flags are registered; there are no combinational paths from inputs to outputs.
- Timer: 26-bit counter.
  - clr_tmr=1 sets it to 0 on the next edge; clr_tmr has priority.
  - Otherwise it increments each cycle while below TMR_CNT and saturates at TMR_CNT.
  - tmr_full = (count == TMR_CNT), decoded from the counter register.
  - The timer is independent of ld_vld.
  - clr_tmr asserted in the same cycle the count reaches TMR_CNT gives count 0 and tmr_full=0 on the next cycle.
- Reset mid-operation: history and timer are lost; the averages ramp up again from 0 over 4 samples.

Test Plan:
- Reset, then idle -> all averages 0, sum_lt_min=1, all other flags 0, tmr_full=0.
- 4× ld_vld with lft=rght=0x180 -> after the 1st strobe lft_avg=0x060. After the 4th, lft_avg=rght_avg=0x180, and 2 cycles later sum_gt_min=1, sum_lt_min=0, diff flags 0.
- Steady lft=0x300, rght=0x100 (4 strobes) -> sum 0x400, diff 0x200, diff_gt_1_4=1, diff_gt_15_16=0.
- Steady lft=0x3F0, rght=0x010 -> diff 0x3E0 > 0x3C0, so diff_gt_1_4=1 and diff_gt_15_16=1. Swap the sides -> identical flags.
- Steady sum=0x200 (lft=rght=0x100) -> sum_gt_min=0 and sum_lt_min=0. Then sum=0x1BE -> sum_lt_min=1.
- TMR_CNT=32: pulse clr_tmr -> tmr_full rises exactly 32 cycles after clr_tmr deasserts and stays high. Pulse clr_tmr again -> tmr_full=0 on the next cycle. Assert rst_n=0 mid-count -> counter 0 immediately.
